// File: rtl/musicbox_pkg.sv
// Shared definitions for the music box sequencer:
// ROM word layout and the sequencer state encoding.
package musicbox_pkg;

    localparam int PITCH_LSB = 0;
    localparam int PITCH_W   = 6;
    localparam int DUR_LSB   = 6;
    localparam int DUR_W     = 5;
    localparam int WORD_W    = 11;

    localparam logic [DUR_W-1:0] DUR_END = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_LATCH,
        S_PLAY,
        S_HALT
    } seq_state_t;

endpackage

// File: rtl/song_sequencer_tick_gen.sv
// Duration tick prescaler: counts 0..DIV-1 while enabled and
// flags the terminal count; clr restarts the count.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        end
    end

    assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/song_sequencer.sv
// Fetch/play sequencer for the music box: walks the selected song ROM
// and holds each note for the duration encoded in the ROM word.
module song_sequencer
    import musicbox_pkg::*;
#(
    parameter int CLKF    = 100_000_000,
    parameter int TICK_HZ = 16,
    parameter int ADDR_W  = 9,
    parameter int LOOP    = 1
) (
    input  logic              clk,
    input  logic              RESET_n,
    input  logic              pause,
    input  logic              song_sel,
    input  logic              skip,
    input  logic [WORD_W-1:0] rom_data1,
    input  logic [WORD_W-1:0] rom_data2,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [WORD_W-1:0] fullnote,
    output logic              note_start,
    output logic              song_end,
    output logic              playing
);
    localparam int TICK_DIV = CLKF / TICK_HZ;

    seq_state_t         r_state;
    seq_state_t         w_state_nx;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_addr_nx;
    logic [PITCH_W-1:0] r_pitch;
    logic [PITCH_W-1:0] w_pitch_nx;
    logic [DUR_W-1:0]   r_dur;
    logic [DUR_W-1:0]   w_dur_nx;
    logic               r_note_start;
    logic               w_note_start_nx;
    logic               r_song_end;
    logic               w_song_end_nx;
    logic               r_pause;
    logic               r_sel_meta;
    logic               r_sel_sync;
    logic               r_sel_prev;

    logic [WORD_W-1:0]  w_word;
    logic [PITCH_W-1:0] w_word_pitch;
    logic [DUR_W-1:0]   w_word_dur;
    logic [PITCH_W-1:0] w_pitch_out;
    logic               w_song_chg;
    logic               w_run;
    logic               w_tick;
    logic               w_clr;
    logic               w_note_done;

    assign w_song_chg   = r_sel_sync ^ r_sel_prev;
    assign w_word       = r_sel_sync ? rom_data2 : rom_data1;
    assign w_word_pitch = w_word[PITCH_LSB +: PITCH_W];
    assign w_word_dur   = w_word[DUR_LSB +: DUR_W];
    assign w_run        = (r_state == S_PLAY) && !r_pause;
    assign w_clr        = (r_state == S_LATCH);
    assign w_note_done  = w_tick && (r_dur == DUR_W'(1));

    tick_gen #(
        .DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(RESET_n),
        .clr  (w_clr),
        .en   (w_run),
        .tick (w_tick)
    );

    // pause is registered so it acts from the cycle after it is sampled
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_sel_meta <= 1'b0;
            r_sel_sync <= 1'b0;
            r_sel_prev <= 1'b0;
            r_pause    <= 1'b0;
        end else begin
            r_sel_meta <= song_sel;
            r_sel_sync <= r_sel_meta;
            r_sel_prev <= r_sel_sync;
            r_pause    <= pause;
        end
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            r_addr       <= '0;
            r_pitch      <= '0;
            r_dur        <= '0;
            r_note_start <= 1'b0;
            r_song_end   <= 1'b0;
        end else begin
            r_addr       <= w_addr_nx;
            r_pitch      <= w_pitch_nx;
            r_dur        <= w_dur_nx;
            r_note_start <= w_note_start_nx;
            r_song_end   <= w_song_end_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_addr_nx       = r_addr;
        w_pitch_nx      = r_pitch;
        w_dur_nx        = r_dur;
        w_note_start_nx = 1'b0;
        w_song_end_nx   = 1'b0;
        if (w_song_chg) begin
            w_state_nx = S_FETCH;
            w_addr_nx  = '0;
            w_pitch_nx = '0;
        end else begin
            unique case (r_state)
                S_IDLE:  w_state_nx = S_FETCH;
                S_FETCH: w_state_nx = S_WAIT;
                S_WAIT:  w_state_nx = S_LATCH;
                S_LATCH: begin
                    if (w_word_dur != DUR_END) begin
                        w_pitch_nx      = w_word_pitch;
                        w_dur_nx        = w_word_dur;
                        w_note_start_nx = 1'b1;
                        w_state_nx      = S_PLAY;
                    end else begin
                        w_song_end_nx = 1'b1;
                        w_addr_nx     = '0;
                        if (LOOP != 0) begin
                            w_state_nx = S_FETCH;
                        end else begin
                            w_pitch_nx = '0;
                            w_state_nx = S_HALT;
                        end
                    end
                end
                S_PLAY: begin
                    if (!r_pause) begin
                        if (w_tick) begin
                            w_dur_nx = r_dur - DUR_W'(1);
                        end
                        if (skip || w_note_done) begin
                            w_addr_nx     = r_addr + ADDR_W'(1);
                            w_song_end_nx = &r_addr;
                            w_state_nx    = S_FETCH;
                        end
                    end
                end
                S_HALT:  w_state_nx = S_HALT;
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    assign w_pitch_out = ((r_state == S_PLAY) && r_pause) ? '0 : r_pitch;

    assign rom_addr   = r_addr;
    assign fullnote   = {{(WORD_W - PITCH_W){1'b0}}, w_pitch_out};
    assign note_start = r_note_start;
    assign song_end   = r_song_end;
    assign playing    = w_run;

endmodule
